// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin bus arbiter with transaction locking.
// A grant is held until the owner pulses done or drops its request, then one
// GAP cycle and one IDLE cycle pass before the next owner can be granted.
// Optional forced release after MAX_HOLD grant cycles: define
// RR_LOCK_ARB_TIMEOUT_EN to enable it; otherwise timeout is tied low.
module rr_lock_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  // Elaboration-time parameter sanity.
  generate
    if (N < 2 || N > 16 || IDW != $clog2(N) || MAX_HOLD < 2) begin : g_bad_param
      $error("rr_lock_arbiter: illegal N/IDW/MAX_HOLD combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state;
  logic [IDW-1:0] last;
  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic           rel;
  logic           limit;

  // Winner search: first set req bit starting at last+1, wrapping at N-1.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // Owner-side release: completion or abandon. Other requesters' done is ignored.
  assign rel = done[gnt_id] | ~req[gnt_id];

`ifdef RR_LOCK_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] hold_cnt;

  // Hold counter: zeroed when a grant is issued, counts every GRANT cycle.
  always_ff @(posedge clk) begin
    if (rst)
      hold_cnt <= '0;
    else if (state == IDLE && win_vld)
      hold_cnt <= '0;
    else if (state == GRANT && !rel && !limit)
      hold_cnt <= hold_cnt + 1'b1;
  end

  assign limit = (state == GRANT) && (hold_cnt == HW'(MAX_HOLD - 1));
`else
  assign limit = 1'b0;
`endif

  // Arbiter FSM with registered outputs; a normal release beats the hold limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= IDW'(N - 1);
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            state  <= GRANT;
            gnt    <= ONE << win_id;
            gnt_id <= win_id;
            last   <= win_id;
            busy   <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            state <= GAP;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (limit) begin
            state   <= GAP;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: directed vector table, hold/timeout sequence,
// then randomized traffic compared against a transaction-level model.
module tb_rr_lock_arbiter;

  localparam int N = 4;
  localparam int IDW = 2;
  localparam int MAX_HOLD = 16;
`ifdef RR_LOCK_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, done, gnt;
  logic [IDW-1:0] gnt_id;
  logic busy, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs after a falling edge, then sample outputs 1ns past the rising edge.
  task automatic apply(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
    @(negedge clk);
    rst = r; req = q; done = d;
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the bus, how many dead cycles remain, who went last.
  int m_owner, m_last, m_hold, m_dead;
  bit m_to;

  function automatic void model_step(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
    m_to = 1'b0;
    if (r) begin
      m_owner = -1; m_last = N - 1; m_hold = 0; m_dead = 0;
    end else if (m_owner >= 0) begin
      if (d[m_owner] || !q[m_owner]) begin
        m_owner = -1; m_dead = 1;
      end else if (TO_EN && m_hold == MAX_HOLD - 1) begin
        m_owner = -1; m_dead = 1; m_to = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && q[(m_last + k) % N]) m_owner = (m_last + k) % N;
      end
      if (m_owner >= 0) begin
        m_last = m_owner; m_hold = 0;
      end
    end
  endfunction

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] d,
                              input logic [3:0] g, input logic [1:0] i, input logic b);
    vecs.push_back('{rst: r, req: q, done: d, gnt: g, id: i, busy: b});
  endfunction

  initial begin
    int n;
    logic [N-1:0] rq, dn;
    logic rr;
    rst = 1'b1; req = '0; done = '0;

    // rst req done | gnt id busy
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);  // reset state
    add(0, 4'b0001, 4'b0000, 4'b0001, 0, 1);  // 1-cycle grant to 0
    add(0, 4'b0001, 4'b0001, 4'b0000, 0, 0);  // done -> GAP
    add(0, 4'b0001, 4'b0000, 4'b0000, 0, 0);  // IDLE
    add(0, 4'b0001, 4'b0000, 4'b0001, 0, 1);  // lone requester regranted
    add(0, 4'b1111, 4'b0001, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 4'b0010, 1, 1);  // rotate to 1
    add(0, 4'b1111, 4'b0010, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 4'b0100, 2, 1);  // rotate to 2
    add(0, 4'b1111, 4'b0100, 4'b0000, 0, 0);
    add(0, 4'b0101, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0101, 4'b0000, 4'b0001, 0, 1);  // search 3,0 -> 0
    add(0, 4'b0101, 4'b0001, 4'b0000, 0, 0);
    add(0, 4'b0101, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0101, 4'b0000, 4'b0100, 2, 1);  // then 2
    add(0, 4'b0101, 4'b0100, 4'b0000, 0, 0);
    add(0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0010, 4'b0000, 4'b0010, 1, 1);  // owner 1
    add(0, 4'b0010, 4'b0100, 4'b0010, 1, 1);  // non-owner done ignored
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);  // abandon -> GAP
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);  // IDLE
    add(0, 4'b0010, 4'b0000, 4'b0010, 1, 1);
    add(1, 4'b0010, 4'b0000, 4'b0000, 0, 0);  // reset mid-grant
    add(0, 4'b1000, 4'b0000, 4'b1000, 3, 1);  // only 3 requesting
    add(0, 4'b1000, 4'b1000, 4'b0000, 0, 0);
    add(1, 4'b1001, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1001, 4'b0000, 4'b0001, 0, 1);  // last=N-1 -> 0 wins over 3
    add(0, 4'b0000, 4'b0001, 4'b0000, 0, 0);  // done+drop: single release
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1000, 4'b0000, 4'b0000, 0, 0);  // still dead? no: IDLE sees req
    vecs[vecs.size()-1].gnt = 4'b1000;
    vecs[vecs.size()-1].id = 3;
    vecs[vecs.size()-1].busy = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      if (vecs[i].busy) chk($sformatf("vec%0d_id", i), gnt_id, vecs[i].id);
      chk($sformatf("vec%0d_timeout", i), timeout, 0);
    end

    // Owner 0 never releases while 1 also waits.
    apply(1, '0, '0);
    apply(0, 4'b0011, '0);
    chk("hold_first", gnt, 4'b0001);
`ifdef RR_LOCK_ARB_TIMEOUT_EN
    n = 1;
    while (gnt == 4'b0001 && n < 40) begin
      chk("hold_no_timeout", timeout, 0);
      apply(0, 4'b0011, '0);
      if (gnt == 4'b0001) n++;
    end
    chk("hold_cycles", n, MAX_HOLD);
    chk("hold_gap_gnt", gnt, 0);
    chk("hold_timeout_pulse", timeout, 1);
    apply(0, 4'b0011, '0);
    chk("hold_idle_timeout", timeout, 0);
    chk("hold_idle_gnt", gnt, 0);
    apply(0, 4'b0011, '0);
    chk("hold_next_owner", gnt, 4'b0010);
`else
    n = 0;
    for (int i = 0; i < 120; i++) begin
      apply(0, 4'b0011, '0);
      if (gnt == 4'b0001 && timeout == 1'b0) n++;
    end
    chk("hold_forever", n, 120);
`endif

    // Randomized traffic against the model.
    apply(1, '0, '0);
    model_step(1, '0, '0);
    rq = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, (b == m_owner) ? 15 : 3) == 0) rq[b] = ~rq[b];
      end
      dn = ($urandom_range(0, 4) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      rr = ($urandom_range(0, 299) == 0);
      apply(rr, rq, dn);
      model_step(rr, rq, dn);
      chk("rnd_gnt", gnt, (m_owner >= 0) ? (N'(1) << m_owner) : '0);
      chk("rnd_busy", busy, m_owner >= 0);
      chk("rnd_timeout", timeout, m_to);
      if (m_owner >= 0) chk("rnd_id", gnt_id, m_owner);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
